// File: rtl/bbq_op_router_pkg.sv
// Shared heap operation types for the BBQ router slice.
// BBQ_STAT_W sizes the optional per-channel handoff counters (BBQ_ROUTER_STATS_EN).
package heap_ops;

    typedef enum logic {
        HEAP_OP_ENQUE     = 1'b0,
        HEAP_OP_DEQUE_MAX = 1'b1
    } heap_op_t;

    localparam int unsigned BBQ_STAT_W = 16;

endpackage

// File: rtl/bbq_op_router_if.sv
// Front-end / heap-side bundle of the BBQ op router.
// slave = router side, master = front-end plus heap instances.
interface bbq_op_router_if
    import heap_ops::*;
#(
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned PRIOR_WIDTH = 6,
    parameter int unsigned NUM_CH      = 2
) ();
    localparam int unsigned CH_IDX_W = $clog2(NUM_CH);

    logic                   in_enq_valid;
    logic                   in_enq_ready;
    logic [DWIDTH-1:0]      in_data;
    logic [PRIOR_WIDTH-1:0] in_prior;
    logic                   in_deq_valid;
    logic                   in_deq_ready;
    logic [CH_IDX_W-1:0]    deq_ptr;
    logic [NUM_CH-1:0]      out_valid;
    logic [NUM_CH-1:0]      out_ready;
    heap_op_t               out_op_type     [NUM_CH];
    logic [DWIDTH-1:0]      out_he_data     [NUM_CH];
    logic [PRIOR_WIDTH-1:0] out_he_priority [NUM_CH];

    modport slave (
        input  in_enq_valid, in_data, in_prior, in_deq_valid, out_ready,
        output in_enq_ready, in_deq_ready, deq_ptr,
               out_valid, out_op_type, out_he_data, out_he_priority
    );

    modport master (
        output in_enq_valid, in_data, in_prior, in_deq_valid, out_ready,
        input  in_enq_ready, in_deq_ready, deq_ptr,
               out_valid, out_op_type, out_he_data, out_he_priority
    );

endinterface

// File: rtl/bbq_router_slot.sv
// One-entry registered output slot with valid/ready handshake.
// The parent only asserts load_i when free_o is high.
module bbq_router_slot
    import heap_ops::*;
#(
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned PRIOR_WIDTH = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  heap_op_t               op_i,
    input  logic [DWIDTH-1:0]      data_i,
    input  logic [PRIOR_WIDTH-1:0] prio_i,
    input  logic                   ready_i,
    output logic                   free_o,
    output logic                   valid_o,
    output heap_op_t               op_o,
    output logic [DWIDTH-1:0]      data_o,
    output logic [PRIOR_WIDTH-1:0] prio_o
);
    logic                   valid_q, valid_d;
    heap_op_t               op_q, op_d;
    logic [DWIDTH-1:0]      data_q, data_d;
    logic [PRIOR_WIDTH-1:0] prio_q, prio_d;

    // Draining and refilling in the same cycle keeps the slot full.
    assign free_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        data_d  = data_q;
        prio_d  = prio_q;
        if (load_i) begin
            valid_d = 1'b1;
            op_d    = op_i;
            data_d  = data_i;
            prio_d  = prio_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            op_q    <= HEAP_OP_ENQUE;
            data_q  <= '0;
            prio_q  <= '0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            data_q  <= data_d;
            prio_q  <= prio_d;
        end
    end

    assign valid_o = valid_q;
    assign op_o    = op_q;
    assign data_o  = data_q;
    assign prio_o  = prio_q;

endmodule

// File: rtl/bbq_op_router.sv
// Routes one enqueue and one deque-max per cycle across NUM_CH heap channels.
// Optional BBQ_ROUTER_STATS_EN adds saturating per-channel handoff counters.
module bbq_op_router
    import heap_ops::*;
#(
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned PRIOR_WIDTH = 6,
    parameter int unsigned NUM_CH      = 2
) (
    input  logic           clk,
    input  logic           rst,
    bbq_op_router_if.slave bus
`ifdef BBQ_ROUTER_STATS_EN
    ,
    output logic [BBQ_STAT_W-1:0] stat_enq_cnt [NUM_CH],
    output logic [BBQ_STAT_W-1:0] stat_deq_cnt [NUM_CH]
`endif
);
    localparam int unsigned CH_IDX_W = $clog2(NUM_CH);

    logic [CH_IDX_W-1:0]    deq_ptr_q, deq_ptr_d;
    logic [CH_IDX_W-1:0]    enq_ch;
    logic [NUM_CH-1:0]      slot_free;
    logic [NUM_CH-1:0]      slot_valid;
    heap_op_t               slot_op   [NUM_CH];
    logic [DWIDTH-1:0]      slot_data [NUM_CH];
    logic [PRIOR_WIDTH-1:0] slot_prio [NUM_CH];
    logic                   deq_ready, enq_ready;
    logic                   deq_acc, enq_acc;

    // The enq channel is always the one after the deq channel, so they never collide.
    assign enq_ch = (deq_ptr_q == CH_IDX_W'(NUM_CH - 1)) ? '0 : deq_ptr_q + CH_IDX_W'(1);

    assign deq_ready = slot_free[deq_ptr_q];
    assign enq_ready = slot_free[enq_ch];
    assign deq_acc   = bus.in_deq_valid & deq_ready;
    assign enq_acc   = bus.in_enq_valid & enq_ready;
    assign deq_ptr_d = deq_acc ? enq_ch : deq_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            deq_ptr_q <= '0;
        end else begin
            deq_ptr_q <= deq_ptr_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [CH_IDX_W-1:0] CH = CH_IDX_W'(c);
        logic is_deq, is_enq;

        assign is_deq = deq_acc && (deq_ptr_q == CH);
        assign is_enq = enq_acc && (enq_ch == CH);

        bbq_router_slot #(
            .DWIDTH      (DWIDTH),
            .PRIOR_WIDTH (PRIOR_WIDTH)
        ) u_slot (
            .clk_i   (clk),
            .rst_i   (rst),
            .load_i  (is_deq | is_enq),
            .op_i    (is_deq ? HEAP_OP_DEQUE_MAX : HEAP_OP_ENQUE),
            .data_i  (is_deq ? '0 : bus.in_data),
            .prio_i  (is_deq ? '0 : bus.in_prior),
            .ready_i (bus.out_ready[c]),
            .free_o  (slot_free[c]),
            .valid_o (slot_valid[c]),
            .op_o    (slot_op[c]),
            .data_o  (slot_data[c]),
            .prio_o  (slot_prio[c])
        );
    end

    assign bus.in_deq_ready    = deq_ready;
    assign bus.in_enq_ready    = enq_ready;
    assign bus.deq_ptr         = deq_ptr_q;
    assign bus.out_valid       = slot_valid;
    assign bus.out_op_type     = slot_op;
    assign bus.out_he_data     = slot_data;
    assign bus.out_he_priority = slot_prio;

`ifdef BBQ_ROUTER_STATS_EN
    logic [BBQ_STAT_W-1:0] stat_enq_q [NUM_CH];
    logic [BBQ_STAT_W-1:0] stat_deq_q [NUM_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                stat_enq_q[c] <= '0;
                stat_deq_q[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (slot_valid[c] && bus.out_ready[c]) begin
                    if (slot_op[c] == HEAP_OP_DEQUE_MAX) begin
                        if (stat_deq_q[c] != '1) stat_deq_q[c] <= stat_deq_q[c] + BBQ_STAT_W'(1);
                    end else begin
                        if (stat_enq_q[c] != '1) stat_enq_q[c] <= stat_enq_q[c] + BBQ_STAT_W'(1);
                    end
                end
            end
        end
    end

    assign stat_enq_cnt = stat_enq_q;
    assign stat_deq_cnt = stat_deq_q;
`endif

endmodule

// File: tb/tb_bbq_op_router.sv
// Bench for bbq_op_router: 2- and 3-channel instances share one randomized stimulus
// stream and are each checked every cycle against a slot-level reference model.
module tb_bbq_op_router;
    import heap_ops::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        enq_v = 1'b0, deq_v = 1'b0;
    logic [31:0] din = '0;
    logic [5:0]  pin = '0;
    logic [1:0]  rdy2 = '1;
    logic [2:0]  rdy3 = '1;

    bbq_op_router_if #(.DWIDTH(32), .PRIOR_WIDTH(6), .NUM_CH(2)) bus2 ();
    bbq_op_router_if #(.DWIDTH(32), .PRIOR_WIDTH(6), .NUM_CH(3)) bus3 ();

    assign bus2.in_enq_valid = enq_v;
    assign bus2.in_deq_valid = deq_v;
    assign bus2.in_data      = din;
    assign bus2.in_prior     = pin;
    assign bus2.out_ready    = rdy2;
    assign bus3.in_enq_valid = enq_v;
    assign bus3.in_deq_valid = deq_v;
    assign bus3.in_data      = din;
    assign bus3.in_prior     = pin;
    assign bus3.out_ready    = rdy3;

`ifdef BBQ_ROUTER_STATS_EN
    logic [15:0] s_enq2 [2], s_deq2 [2], s_enq3 [3], s_deq3 [3];
`endif

    bbq_op_router #(.DWIDTH(32), .PRIOR_WIDTH(6), .NUM_CH(2)) u_dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
`ifdef BBQ_ROUTER_STATS_EN
        , .stat_enq_cnt (s_enq2), .stat_deq_cnt (s_deq2)
`endif
    );

    bbq_op_router #(.DWIDTH(32), .PRIOR_WIDTH(6), .NUM_CH(3)) u_dut3 (
        .clk (clk), .rst (rst), .bus (bus3)
`ifdef BBQ_ROUTER_STATS_EN
        , .stat_enq_cnt (s_enq3), .stat_deq_cnt (s_deq3)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Reference model: per DUT k (0 -> 2 channels, 1 -> 3 channels)
    int          nch [2] = '{2, 3};
    bit          m_v    [2][3];
    bit          m_deq  [2][3];
    logic [31:0] m_data [2][3];
    logic [5:0]  m_prio [2][3];
    int          m_ptr  [2];
    int          m_se   [2][3];
    int          m_sd   [2][3];

    // Observed DUT values
    bit          o_v    [2][3];
    bit          o_deq  [2][3];
    logic [31:0] o_data [2][3];
    logic [5:0]  o_prio [2][3];
    int          o_ptr  [2];
    bit          o_dr   [2];
    bit          o_er   [2];
    int          o_se   [2][3];
    int          o_sd   [2][3];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0;
            for (int c = 0; c < 3; c++) begin
                m_v[k][c] = 0; m_deq[k][c] = 0; m_data[k][c] = '0; m_prio[k][c] = '0;
                m_se[k][c] = 0; m_sd[k][c] = 0;
            end
        end
    endtask

    task automatic sample();
        for (int c = 0; c < 2; c++) begin
            o_v[0][c]    = bus2.out_valid[c];
            o_deq[0][c]  = (bus2.out_op_type[c] == HEAP_OP_DEQUE_MAX);
            o_data[0][c] = bus2.out_he_data[c];
            o_prio[0][c] = bus2.out_he_priority[c];
        end
        for (int c = 0; c < 3; c++) begin
            o_v[1][c]    = bus3.out_valid[c];
            o_deq[1][c]  = (bus3.out_op_type[c] == HEAP_OP_DEQUE_MAX);
            o_data[1][c] = bus3.out_he_data[c];
            o_prio[1][c] = bus3.out_he_priority[c];
        end
        o_ptr[0] = int'(bus2.deq_ptr);       o_ptr[1] = int'(bus3.deq_ptr);
        o_dr[0]  = bus2.in_deq_ready;        o_dr[1]  = bus3.in_deq_ready;
        o_er[0]  = bus2.in_enq_ready;        o_er[1]  = bus3.in_enq_ready;
`ifdef BBQ_ROUTER_STATS_EN
        for (int c = 0; c < 2; c++) begin o_se[0][c] = int'(s_enq2[c]); o_sd[0][c] = int'(s_deq2[c]); end
        for (int c = 0; c < 3; c++) begin o_se[1][c] = int'(s_enq3[c]); o_sd[1][c] = int'(s_deq3[c]); end
`endif
    endtask

    // Called with inputs already driven (clock low); checks, advances the model, then one clock.
    task automatic step();
        logic [2:0] rv;
        bit fr [3];
        bit dr, er;
        int n, d, e;
        #1;
        sample();
        for (int k = 0; k < 2; k++) begin
            n  = nch[k];
            d  = m_ptr[k];
            e  = (d + 1) % n;
            rv = (k == 0) ? {1'b0, rdy2} : rdy3;
            for (int c = 0; c < n; c++) fr[c] = !m_v[k][c] || rv[c];
            dr = fr[d];
            er = fr[e];
            check_eq($sformatf("k%0d_deq_ready", k), 64'(o_dr[k]), 64'(dr));
            check_eq($sformatf("k%0d_enq_ready", k), 64'(o_er[k]), 64'(er));
            check_eq($sformatf("k%0d_deq_ptr", k), 64'(o_ptr[k]), 64'(d));
            for (int c = 0; c < n; c++) begin
                check_eq($sformatf("k%0d_valid%0d", k, c), 64'(o_v[k][c]), 64'(m_v[k][c]));
                if (m_v[k][c])
                    check_eq($sformatf("k%0d_slot%0d", k, c),
                             64'({o_deq[k][c], o_data[k][c], o_prio[k][c]}),
                             64'({m_deq[k][c], m_data[k][c], m_prio[k][c]}));
`ifdef BBQ_ROUTER_STATS_EN
                check_eq($sformatf("k%0d_stat_enq%0d", k, c), 64'(o_se[k][c]), 64'(m_se[k][c]));
                check_eq($sformatf("k%0d_stat_deq%0d", k, c), 64'(o_sd[k][c]), 64'(m_sd[k][c]));
`endif
            end
            if (!rst) begin
                for (int c = 0; c < n; c++) begin
                    if (m_v[k][c] && rv[c]) begin
                        if (m_deq[k][c]) begin if (m_sd[k][c] < 65535) m_sd[k][c]++; end
                        else begin if (m_se[k][c] < 65535) m_se[k][c]++; end
                        m_v[k][c] = 0;
                    end
                end
                if (deq_v && dr) begin
                    m_v[k][d] = 1; m_deq[k][d] = 1; m_data[k][d] = '0; m_prio[k][d] = '0;
                    m_ptr[k] = e;
                end
                if (enq_v && er) begin
                    m_v[k][e] = 1; m_deq[k][e] = 0; m_data[k][e] = din; m_prio[k][e] = pin;
                end
            end
        end
        if (rst) model_reset();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        enq_v = 0; deq_v = 0; din = '0; pin = '0; rdy2 = '1; rdy3 = '1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    int seq [4] = '{0, 1, 2, 0};
    int dch, ech;

    initial begin
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();

        // Reset state and idle readiness
        #1; sample();
        check_eq("rst_valid2", 64'({o_v[0][1], o_v[0][0]}), 64'b00);
        check_eq("rst_ptr2", 64'(o_ptr[0]), 64'd0);
        check_eq("rst_rdy2", 64'({o_dr[0], o_er[0]}), 64'b11);
        for (int c = 0; c < 3; c++)
            check_eq($sformatf("rst_slot3_%0d", c),
                     64'({o_deq[1][c], o_data[1][c], o_prio[1][c]}), 64'd0);
        step();

        // Paired enqueue + dequeue on two channels, twice
        enq_v = 1; deq_v = 1; din = 32'hA5; pin = 6'd3;
        step();
        sample();
        check_eq("t2a_ch0", 64'({o_v[0][0], o_deq[0][0], o_data[0][0], o_prio[0][0]}), 64'({2'b11, 38'd0}));
        check_eq("t2a_ch1", 64'({o_v[0][1], o_deq[0][1], o_data[0][1], o_prio[0][1]}), 64'({2'b10, 32'hA5, 6'd3}));
        check_eq("t2a_ptr", 64'(o_ptr[0]), 64'd1);
        step();
        sample();
        check_eq("t2b_ch1", 64'({o_v[0][1], o_deq[0][1], o_data[0][1], o_prio[0][1]}), 64'({2'b11, 38'd0}));
        check_eq("t2b_ch0", 64'({o_v[0][0], o_deq[0][0], o_data[0][0], o_prio[0][0]}), 64'({2'b10, 32'hA5, 6'd3}));
        check_eq("t2b_ptr", 64'(o_ptr[0]), 64'd0);

        // Three-channel rotation with wrap
        idle_inputs();
        do_reset();
        enq_v = 1; deq_v = 1; din = 32'h1234; pin = 6'd7;
        for (int i = 0; i < 4; i++) begin
            #1; sample();
            check_eq($sformatf("t3_ptr%0d", i), 64'(o_ptr[1]), 64'(seq[i]));
            step();
            sample();
            dch = seq[i];
            ech = (seq[i] + 1) % 3;
            check_eq($sformatf("t3_deq%0d", i), 64'({o_v[1][dch], o_deq[1][dch]}), 64'b11);
            check_eq($sformatf("t3_enq%0d", i), 64'({o_v[1][ech], o_deq[1][ech], o_data[1][ech]}), 64'({2'b10, 32'h1234}));
        end
        check_eq("t3_ptr_end", 64'(o_ptr[1]), 64'd1);

        // Backpressure on channel 1 of the 2-channel router
        idle_inputs();
        do_reset();
        enq_v = 1; din = 32'hA5; pin = 6'd3;
        step();
        rdy2 = 2'b01; enq_v = 1; din = 32'h5A; pin = 6'd9; deq_v = 1;
        #1; sample();
        check_eq("t4_enq_ready", 64'(o_er[0]), 64'd0);
        check_eq("t4_deq_ready", 64'(o_dr[0]), 64'd1);
        step();
        enq_v = 0; deq_v = 0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check_eq($sformatf("t4_hold%0d", i),
                     64'({o_v[0][1], o_deq[0][1], o_data[0][1], o_prio[0][1]}), 64'({2'b10, 32'hA5, 6'd3}));
            if (i < 2) step();
        end
        rdy2 = 2'b11; deq_v = 1;
        #1; sample();
        check_eq("t4_release_ready", 64'(o_dr[0]), 64'd1);
        step();
        sample();
        check_eq("t4_refill", 64'({o_v[0][1], o_deq[0][1], o_data[0][1]}), 64'({2'b11, 32'd0}));

        // Reset while channel 0 is stalled
        idle_inputs();
        do_reset();
        rdy2 = 2'b00; deq_v = 1;
        step();
        deq_v = 0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sample();
        check_eq("t5_valid", 64'({o_v[0][1], o_v[0][0]}), 64'b00);
        check_eq("t5_ptr", 64'(o_ptr[0]), 64'd0);
        rdy2 = 2'b11;
        step();

        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            enq_v = 1'($urandom_range(0, 1));
            deq_v = 1'($urandom_range(0, 1));
            din   = $urandom;
            pin   = 6'($urandom);
            rdy2  = 2'($urandom);
            rdy3  = 3'($urandom);
            rst   = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0;

`ifdef BBQ_ROUTER_STATS_EN
        // Saturation of the deque counter on channel 0
        idle_inputs();
        do_reset();
        deq_v = 1;
        for (int i = 0; i < 2 * 65536 + 4; i++) step();
        check_eq("t6_sat", 64'(s_deq2[0]), 64'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
